serial_addsub: RTL
==================

// Module: serial_addsub
// PURPOSE
//  Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry flop, processing one bit per clock, LSB first.
//  Counterpart to the parallel ripple_carry_adder; supports subtraction (A - B) via B inversion and carry-in = 1.
//  Sits behind a valid/ready request port and a valid/ready result port, so it is an area-cheap arithmetic unit
//  for datapaths that can tolerate WIDTH-cycle latency.
// PARAMETERS
//  WIDTH  4  operand/result width in bits; legal range 2..32
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      request present on A, B, sub
//  in_ready   out  1      unit can accept a request (high only in IDLE)
//  A          in   WIDTH  operand A (unsigned or two's complement)
//  B          in   WIDTH  operand B
//  sub        in   1      0: A+B, 1: A-B
//  out_valid  out  1      result fields valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  A+B or A-B, mod 2^WIDTH
//  carry      out  1      add: carry out; sub: borrow (1 iff A<B unsigned)
//  ovf        out  1      signed overflow (two's complement)
//  zero       out  1      result == 0
// BEHAVIOUR
//  Reset (synchronous, active-high): state=IDLE, in_ready=1, out_valid=0; result, carry, ovf, zero=0; internal regs cleared.
//   rst overrides everything, including mid-SHIFT or DONE; the in-flight operation is discarded, no out_valid.
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready at edge E0:
//   - latch opA=A, opB = sub ? ~B : B
//   - c = sub, bit counter = 0, go to SHIFT
//   - inputs are ignored after E0
//  SHIFT: in_ready=0, out_valid=0. Each edge:
//   - s = opA[0]^opB[0]^c; c <= majority(opA[0], opB[0], c)
//   - shift s into result register from MSB side; shift opA, opB right by 1; counter++
//   - on the WIDTH-th shift edge (E0+WIDTH): go to DONE; record sign bits of A, B', s for the ovf computation
//  DONE: out_valid=1. Fields are stable until handshake.
//   - result = final sum
//   - carry = sub ? ~c : c
//   - ovf = (A[MSB]==B'[MSB]) && (s[MSB]!=A[MSB])
//   - zero = (result==0)
//  Latency: out_valid rises WIDTH cycles after the accept edge (first visible in cycle E0+WIDTH).
//  Result handshake: on out_valid&&out_ready go to IDLE, out_valid=0 next cycle, in_ready=1 next cycle.
//   - Back-pressure: out_ready low holds DONE and all outputs indefinitely.
//   - No same-cycle pass-through: a new request is accepted no earlier than the cycle after result hand-off.
//   - Throughput: one op per WIDTH+2 cycles with out_ready tied high.
//  Output regs (result, carry, ovf, zero) may hold stale values outside DONE; consumers qualify with out_valid.
//  in_valid in SHIFT/DONE is ignored, not queued. out_ready outside DONE is ignored.
//  Width/arith rules: results wrap mod 2^WIDTH; no saturation.
//   - sub with B=0: carry=0.
//   - sub with A==B: result=0, zero=1, carry=0.
// TESTING (WIDTH=4; check out_valid timing = accept+4 in every case)
//  1. add A=0101, B=0011 -> result=1000, carry=0, ovf=1 (5+3 signed overflow), zero=0.
//  2. add A=1111, B=0001 -> result=0000, carry=1, zero=1, ovf=0; then add A=1010, B=1010 -> 0100, carry=1, ovf=1.
//  3. sub A=0011, B=0101 -> result=1110, carry(borrow)=1, ovf=0; sub A=1000, B=0001 -> 0111, carry=0, ovf=1.
//  4. back-pressure: out_ready=0 for 6 cycles after out_valid -> outputs stable, in_ready=0;
//     in_valid pulsed meanwhile is not accepted; out_ready=1 -> out_valid falls next cycle, in_ready=1.
//  5. reset mid-op: assert rst 2 cycles after accepting 0111+0111 -> next cycle IDLE, all outputs 0, no out_valid;
//     new op 0111+0111 -> 1110, carry=0, ovf=1.
//  6. exhaustive: all 16x16x2 A/B/sub combinations with out_ready=1,
//     compared against a reference model (A+B / A-B, carry/borrow, ovf, zero).

Source files
------------

// File: rtl/serial_addsub_if.sv
// Request/result bundle for the bit-serial adder/subtractor.
// The slave side is the arithmetic unit; the master side issues operands and consumes results.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;
  logic             zero;

  modport slave (
    input  in_valid, A, B, sub, out_ready,
    output in_ready, out_valid, result, carry, ovf, zero
  );

  modport master (
    output in_valid, A, B, sub, out_ready,
    input  in_ready, out_valid, result, carry, ovf, zero
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell and a carry flop, LSB first.
// Accepts one request in IDLE, shifts for WIDTH cycles, then holds the result until handed off.
module serial_addsub #(
  parameter int unsigned WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  serial_addsub_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             c;
  logic             sub_q;
  logic [CntW-1:0]  cnt;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;

  logic             s_bit;
  logic             c_nxt;
  logic [WIDTH-1:0] res_nxt;

  assign s_bit   = op_a[0] ^ op_b[0] ^ c;
  assign c_nxt   = (op_a[0] & op_b[0]) | (op_a[0] & c) | (op_b[0] & c);
  // Sum bits enter from the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign res_nxt = {s_bit, result_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      op_a        <= '0;
      op_b        <= '0;
      c           <= 1'b0;
      sub_q       <= 1'b0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.in_valid) begin
            op_a       <= bus.A;
            op_b       <= bus.sub ? ~bus.B : bus.B;
            c          <= bus.sub;
            sub_q      <= bus.sub;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= StShift;
          end
        end
        StShift: begin
          op_a     <= op_a >> 1;
          op_b     <= op_b >> 1;
          c        <= c_nxt;
          result_q <= res_nxt;
          cnt      <= cnt + 1'b1;
          if (cnt == CntW'(WIDTH - 1)) begin
            // op_a[0]/op_b[0] now hold the sign bits of A and B'.
            state       <= StDone;
            out_valid_q <= 1'b1;
            carry_q     <= sub_q ? ~c_nxt : c_nxt;
            ovf_q       <= (op_a[0] == op_b[0]) && (s_bit != op_a[0]);
            zero_q      <= (res_nxt == '0);
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule
